// File: rtl/my_gates_pkg.sv
// Shared constants and helpers for the arbitrated N-to-1 mux.
package my_gates_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width; never below one bit so a 1-channel select still has a port.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// Grant selection: fixed priority from channel 0, or round-robin from a rotating pointer.
module my_rr_arbiter
    import my_gates_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int RR   = MODE_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic [SELW-1:0] ptr;
    logic            hit;

    // Search N slots upward from the base with wrap; the first requester wins.
    always_comb begin
        int              base;
        int              idx;
        logic [SELW-1:0] idx_w;
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        idx       = 0;
        idx_w     = '0;
        base      = (RR == MODE_RR) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = SELW'(idx);
            if (!hit && en && rst_n && req[idx_w]) begin
                hit          = 1'b1;
                grant[idx_w] = 1'b1;
                grant_idx    = idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hit && (RR == MODE_RR)) begin
            ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/my_arb_mux_n.sv
// N-channel valid/ready arbiter feeding a single registered output stage.
module my_arb_mux_n
    import my_gates_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int W    = 16,
    parameter  int RR   = MODE_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            all_valid,
    output logic            any_valid
);

    logic            load;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            any_grant;
    logic [W-1:0]    mux_data;

    logic [W-1:0]    data_p1;
    logic [SELW-1:0] sel_p1;
    logic            vld_p1;
    logic            all_p1;
    logic            any_p1;

    // The output register can take a new word when empty or being drained this cycle.
    assign load      = !vld_p1 || out_ready;
    assign any_grant = |grant;
    assign in_ready  = grant;

    my_rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .en        (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                mux_data = in_data[i*W +: W];
            end
        end
    end

    // ---- stage p0 -> p1: registered output ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p1 <= '0;
            sel_p1  <= '0;
            vld_p1  <= 1'b0;
            all_p1  <= 1'b0;
            any_p1  <= 1'b0;
        end else begin
            all_p1 <= &in_valid;
            any_p1 <= |in_valid;
            if (load) begin
                vld_p1 <= any_grant;
                if (any_grant) begin
                    data_p1 <= mux_data;
                    sel_p1  <= grant_idx;
                end
            end
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;
    assign all_valid = all_p1;
    assign any_valid = any_p1;

endmodule

// File: tb/tb_my_arb_mux_n.sv
// Scoreboard bench for my_arb_mux_n: round-robin, fixed-priority and 3-channel instances.
module tb_my_arb_mux_n;

    typedef struct {
        logic [15:0] data;
        int          sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] a_data;
    logic [7:0]   a_valid, a_ready;
    logic [15:0]  a_odata;
    logic [2:0]   a_osel;
    logic         a_ovalid, a_oready, a_all, a_any;

    logic [127:0] b_data;
    logic [7:0]   b_valid, b_ready;
    logic [15:0]  b_odata;
    logic [2:0]   b_osel;
    logic         b_ovalid, b_oready, b_all, b_any;

    logic [2:0]   c_data, c_valid, c_ready;
    logic [0:0]   c_odata;
    logic [1:0]   c_osel;
    logic         c_ovalid, c_oready, c_all, c_any;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    logic [7:0] a_prev_v;
    int total = 0;
    int bad = 0;

    my_arb_mux_n #(.N(8), .W(16), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_oready),
        .all_valid(a_all), .any_valid(a_any));

    my_arb_mux_n #(.N(8), .W(16), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_oready),
        .all_valid(b_all), .any_valid(b_any));

    my_arb_mux_n #(.N(3), .W(1), .RR(1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_oready),
        .all_valid(c_all), .any_valid(c_any));

    task automatic do_reset();
        rst_n   = 1'b0;
        a_valid = '0;
        b_valid = '0;
        c_valid = '0;
        a_oready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        qc.delete();
        a_prev_v = '0;
    endtask

    // One cycle on the round-robin instance with out_ready high; g < 0 means no grant expected.
    task automatic cycle_a(input logic [7:0] v, input int g);
        exp_t e;
        logic [7:0] er;
        logic want_v;
        a_valid = v;
        @(negedge clk);
        want_v = (qa.size() > 0);
        total++;
        if (a_ovalid !== want_v) begin
            bad++;
            $display("FAIL a_out_valid got=%b want=%b t=%0t", a_ovalid, want_v, $time);
        end
        if (a_ovalid === 1'b1 && qa.size() > 0) begin
            e = qa.pop_front();
            total++;
            if (a_odata !== e.data || int'(a_osel) !== e.sel) begin
                bad++;
                $display("FAIL a_out got=%h/%0d want=%h/%0d t=%0t", a_odata, a_osel, e.data, e.sel, $time);
            end
        end
        er = (g < 0) ? 8'h00 : 8'(1 << g);
        total++;
        if (a_ready !== er) begin
            bad++;
            $display("FAIL a_in_ready got=%b want=%b t=%0t", a_ready, er, $time);
        end
        total++;
        if (a_all !== (&a_prev_v) || a_any !== (|a_prev_v)) begin
            bad++;
            $display("FAIL a_all_any got=%b%b want=%b%b t=%0t", a_all, a_any, &a_prev_v, |a_prev_v, $time);
        end
        if (g >= 0) begin
            e.data = 16'(16'h1000 + g);
            e.sel  = g;
            qa.push_back(e);
        end
        a_prev_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 8'hFF;
        a_oready = 1'b1;
        @(negedge clk);
        total++;
        if (a_ready !== 8'h00) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=00000000", a_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0 || a_osel !== 3'd0 || a_all !== 1'b0 || a_any !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h s=%0d all=%b any=%b want 0/0000/0/0/0",
                     a_ovalid, a_odata, a_osel, a_all, a_any);
        end
        do_reset();
    endtask

    task automatic test_rr_sweep();
        do_reset();
        for (int k = 0; k < 9; k++) cycle_a(8'hFF, k % 8);
        cycle_a(8'h00, -1);
        cycle_a(8'h00, -1);
    endtask

    task automatic test_fixed();
        exp_t e;
        do_reset();
        b_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++;
            if (b_ovalid !== (qb.size() > 0)) begin
                bad++;
                $display("FAIL b_out_valid got=%b k=%0d", b_ovalid, k);
            end
            if (b_ovalid === 1'b1 && qb.size() > 0) begin
                e = qb.pop_front();
                total++;
                if (b_odata !== e.data || int'(b_osel) !== e.sel) begin
                    bad++;
                    $display("FAIL b_out got=%h/%0d want=%h/%0d", b_odata, b_osel, e.data, e.sel);
                end
            end
            total++;
            if (b_ready !== 8'b0000_0001) begin
                bad++;
                $display("FAIL b_in_ready got=%b want=00000001", b_ready);
            end
            e.data = 16'h1000;
            e.sel  = 0;
            qb.push_back(e);
            @(posedge clk);
            #1;
        end
        b_valid = 8'h00;
        @(negedge clk);
        e = qb.pop_front();
        total++;
        if (b_ovalid !== 1'b1 || b_odata !== e.data || int'(b_osel) !== e.sel) begin
            bad++;
            $display("FAIL b_drain got=%b/%h/%0d want=1/%h/%0d", b_ovalid, b_odata, b_osel, e.data, e.sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        a_valid  = 8'h20;
        a_oready = 1'b0;
        @(negedge clk);
        total++;
        if (a_ovalid !== 1'b0 || a_ready !== 8'h20) begin
            bad++;
            $display("FAIL stall_first got=%b/%b want=0/00100000", a_ovalid, a_ready);
        end
        e.data = 16'h1005;
        e.sel  = 5;
        qa.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            total++;
            if (a_ovalid !== 1'b1 || a_odata !== 16'h1005 || a_osel !== 3'd5 || a_ready !== 8'h00) begin
                bad++;
                $display("FAIL stall_hold got=%b/%h/%0d/%b want=1/1005/5/00000000",
                         a_ovalid, a_odata, a_osel, a_ready);
            end
        end
        @(posedge clk);
        #1;
        a_oready = 1'b1;
        @(negedge clk);
        e = qa.pop_front();
        total++;
        if (a_ready !== 8'h20 || a_odata !== e.data || int'(a_osel) !== e.sel) begin
            bad++;
            $display("FAIL stall_release got=%b/%h/%0d want=00100000/%h/%0d", a_ready, a_odata, a_osel, e.data, e.sel);
        end
        qa.push_back(e);
        @(posedge clk);
        #1;
        a_prev_v = 8'h20;
        cycle_a(8'h00, -1);
        cycle_a(8'h00, -1);
        total++;
        if (a_odata !== 16'h1005 || a_osel !== 3'd5) begin
            bad++;
            $display("FAIL idle_hold got=%h/%0d want=1005/5", a_odata, a_osel);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 6; g++) cycle_a(8'hFF, g);
        cycle_a(8'h84, 7);
        cycle_a(8'h84, 2);
        cycle_a(8'hFF, 3);
        cycle_a(8'h00, -1);
        cycle_a(8'h00, -1);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        for (int g = 0; g < 4; g++) cycle_a(8'hFF, g);
        rst_n   = 1'b0;
        a_valid = 8'hFF;
        @(negedge clk);
        total++;
        if (a_ready !== 8'h00) begin
            bad++;
            $display("FAIL midrst_in_ready got=%b want=00000000", a_ready);
        end
        e = qa.pop_front();
        total++;
        if (a_ovalid !== 1'b1 || int'(a_osel) !== e.sel) begin
            bad++;
            $display("FAIL midrst_pending got=%b/%0d want=1/%0d", a_ovalid, a_osel, e.sel);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_prev_v = 8'h00;
        total++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0 || a_osel !== 3'd0 || a_any !== 1'b0 || a_all !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got v=%b d=%h s=%0d any=%b all=%b want 0/0000/0/0/0",
                     a_ovalid, a_odata, a_osel, a_any, a_all);
        end
        cycle_a(8'h84, 2);
        cycle_a(8'h00, -1);
        cycle_a(8'h00, -1);
    endtask

    task automatic test_n3();
        exp_t e;
        int g;
        do_reset();
        c_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 0 : 2;
            @(negedge clk);
            total++;
            if (c_ovalid !== (qc.size() > 0)) begin
                bad++;
                $display("FAIL c_out_valid got=%b k=%0d", c_ovalid, k);
            end
            if (c_ovalid === 1'b1 && qc.size() > 0) begin
                e = qc.pop_front();
                total++;
                if (c_odata[0] !== e.data[0] || int'(c_osel) !== e.sel || c_osel > 2'd2) begin
                    bad++;
                    $display("FAIL c_out got=%b/%0d want=%b/%0d", c_odata, c_osel, e.data[0], e.sel);
                end
            end
            total++;
            if (c_ready !== 3'(1 << g)) begin
                bad++;
                $display("FAIL c_in_ready got=%b want=%b", c_ready, 3'(1 << g));
            end
            e.data = (g == 2) ? 16'h1 : 16'h0;
            e.sel  = g;
            qc.push_back(e);
            @(posedge clk);
            #1;
        end
        c_valid = 3'b000;
        @(negedge clk);
        e = qc.pop_front();
        total++;
        if (c_ovalid !== 1'b1 || c_odata[0] !== e.data[0] || int'(c_osel) !== e.sel) begin
            bad++;
            $display("FAIL c_drain got=%b/%b/%0d want=1/%b/%0d", c_ovalid, c_odata, c_osel, e.data[0], e.sel);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            a_data[i*16 +: 16] = 16'(16'h1000 + i);
        end
        b_data   = a_data;
        c_data   = 3'b100;
        a_valid  = '0;
        b_valid  = '0;
        c_valid  = '0;
        a_oready = 1'b1;
        b_oready = 1'b1;
        c_oready = 1'b1;
        a_prev_v = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_rr_sweep();
        test_fixed();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/my_arb_mux_n.md
MY_ARB_MUX_N -- requirements
Module: my_arb_mux_n

Interface
REQ-001 Parameter N, default 8: number of input channels; legal values 2..16.
REQ-002 Parameter W, default 16: data width per channel in bits; legal values 1..64.
REQ-003 Parameter RR, default 1: arbitration mode; 1 = round-robin, 0 = fixed priority with channel 0 highest.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_data  in  N x W  per-channel data; channel i occupies bits [i*W +: W].
REQ-008 in_valid  in  N  per-channel request.
REQ-009 in_ready  out  N  per-channel accept, one-hot or zero; combinational.
REQ-010 out_data  out  W  registered data of the granted channel.
REQ-011 out_sel  out  SELW = clog2(N)  registered index of the channel that supplied out_data.
REQ-012 out_valid  out  1  registered; out_data and out_sel are valid.
REQ-013 out_ready  in  1  downstream accept.
REQ-014 all_valid  out  1  registered AND-reduce of in_valid.
REQ-015 any_valid  out  1  registered OR-reduce of in_valid.

Function
REQ-016 A transfer on channel i SHALL occur in any cycle where in_valid[i] and in_ready[i] are both 1.
REQ-017 load = !out_valid || out_ready; in_ready SHALL be all-zero whenever load = 0 or rst_n = 0.
REQ-018 When load = 1 and any in_valid is 1, in_ready SHALL be set for exactly one requesting channel, the grant g.
REQ-019 RR=0: g SHALL be the lowest-indexed requesting channel.
REQ-020 RR=1: g SHALL be the first requesting channel at or after pointer ptr, searching upward with wrap from N-1 to 0.
REQ-021 On a grant with RR=1, ptr SHALL become (g+1) mod N on the next edge; otherwise ptr SHALL hold its value.
REQ-022 On a grant, the next edge SHALL load out_data = in_data[g], set out_sel = g and set out_valid = 1; latency is 1 cycle.
REQ-023 When load = 1 and no channel requests, out_valid SHALL become 0 and out_data and out_sel SHALL hold their values.
REQ-024 When out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL hold their values and no grant SHALL be issued.
REQ-025 With a continuous out_ready = 1, the block SHALL sustain one transfer per cycle, with no bubble between back-to-back grants.
REQ-026 all_valid and any_valid SHALL equal the reductions of in_valid sampled one cycle earlier.
REQ-027 Deasserting in_valid[i] without a transfer is permitted; the block SHALL NOT latch any request.

Reset
REQ-028 While rst_n = 0 at an edge, the next state SHALL be: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, all_valid = 0, any_valid = 0.
REQ-029 Reset asserted mid-transfer SHALL discard a pending out_data, and no transfer SHALL be counted in that cycle.
REQ-030 On the first cycle after reset, arbitration SHALL start with channel 0 as highest priority in both modes.

Structure
REQ-031 Package my_gates_pkg SHALL hold the function sel_width(N) = max(1, clog2(N)) and the RR/FIXED mode constants.
REQ-032 Grant selection and ptr SHALL be in the sub-module my_rr_arbiter, with ports clk, rst_n, req[N], en, grant[N], grant_idx.
REQ-033 The data path SHALL be a parametrised N-to-1 mux of width W, indexed by grant_idx, with no latches.

Verification
REQ-034 N=8, W=16, RR=1, out_ready=1, all in_valid=1, in_data[i]=16'h1000+i -> out_sel follows 0,1,...,7,0 and out_data follows 16'h1000..16'h1007, 16'h1000, starting 1 cycle after reset release; all_valid = 1.
REQ-035 Same stimulus with RR=0 -> every output has out_sel=0 and out_data=16'h1000; in_ready = 8'b0000_0001 on every cycle.
REQ-036 Only in_valid[5] high and out_ready held 0 for 3 cycles -> one grant only; out_valid=1, out_data=16'h1005 and out_sel=5 stable for 3 cycles, in_ready=0; on out_ready=1, the next grant goes to channel 5.
REQ-037 RR=1, ptr=6, requests on channels 2 and 7 -> grant goes to 7, then 2 (wrap); ptr ends at 3.
REQ-038 rst_n=0 for 1 cycle while out_valid=1 with ptr=4 -> next cycle out_valid=0, out_data=0, out_sel=0, any_valid=0, and the next grant comes from the lowest requester.
REQ-039 N=3, W=1, RR=1, in_valid=3'b101 -> grants alternate 0,2,0; out_sel stays within 0..2.
